// File: rtl/ps2_rx_fifo_if.sv
// Key-event output port of ps2_rx_fifo: valid/ready handshake carrying
// one decoded scan-code event per transfer.
interface ps2_rx_fifo_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_break;

  // Producer side (the receiver).
  modport master (
    output out_valid,
    output out_code,
    output out_ext,
    output out_break,
    input  out_ready
  );

  // Consumer side.
  modport slave (
    input  out_valid,
    input  out_code,
    input  out_ext,
    input  out_break,
    output out_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deserialiser with
// idle timeout, E0/F0 prefix folding, and a first-word-fall-through event FIFO.
// Optional build macro: PS2_RX_TYPEMATIC_FILTER_EN drops repeated make codes
// (key auto-repeat) until a break, error or reset intervenes.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_rx_fifo_if.master     evt,
  output logic              overflow,
  output logic [7:0]        err_cnt,
  output logic [7:0]        break_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] ck_sync, dt_sync;
  logic                   ck_prev;
  logic                   strobe;
  logic                   dbit;

  // Idle PS/2 lines are high, so reset the chains high to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ck_sync <= '1;
      dt_sync <= '1;
      ck_prev <= 1'b1;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], ps2_clk};
      dt_sync <= {dt_sync[SYNC_STAGES-2:0], ps2_data};
      ck_prev <= ck_sync[SYNC_STAGES-1];
    end
  end

  assign strobe = ck_prev & ~ck_sync[SYNC_STAGES-1];
  assign dbit   = dt_sync[SYNC_STAGES-1];

  // ------------------------------------------------------- deserialiser
  logic [3:0]      bit_cnt;
  logic [9:0]      sh;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            frame_done, frame_ok, frame_bad;
  logic [7:0]      rx_byte;

  assign timeout    = (bit_cnt != 4'd0) && !strobe && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign frame_done = strobe && (bit_cnt == 4'd10);
  // start bit low, stop bit (live sample) high, odd parity over data+parity
  assign frame_ok   = frame_done && !sh[0] && dbit && (^sh[9:1]);
  assign frame_bad  = frame_done && !frame_ok;
  assign rx_byte    = sh[8:1];

  // Bit capture, frame counter and inter-strobe watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 4'd0;
      sh      <= '0;
      to_cnt  <= '0;
    end else if (strobe) begin
      to_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        sh[bit_cnt] <= dbit;
        bit_cnt     <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (timeout) begin
        bit_cnt <= 4'd0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end else begin
      to_cnt <= '0;
    end
  end

  // ------------------------------------------------------------ decoder
  logic ext_f, brk_f;
  logic is_e0, is_f0;
  logic push_req;     // a complete key event was decoded this cycle
  logic rep_drop;     // event suppressed as a typematic repeat
  logic wr_req;
  logic rx_err;

  assign is_e0    = (rx_byte == 8'hE0);
  assign is_f0    = (rx_byte == 8'hF0);
  assign push_req = frame_ok && !is_e0 && !is_f0;
  assign rx_err   = frame_bad || timeout;

  // Prefix flags accumulate until a non-prefix byte consumes them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (rx_err) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (frame_ok) begin
      if (is_e0)      ext_f <= 1'b1;
      else if (is_f0) brk_f <= 1'b1;
      else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- FIFO
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, wr_en, ovf_set;
  logic [9:0]  head;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = evt.out_valid && evt.out_ready;
  assign wr_req  = push_req && !rep_drop;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en   = wr_req && (!full || pop);
  assign ovf_set = wr_req && full && !pop;

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_key;   // {ext, code} of the most recent accepted make

  assign rep_drop = push_req && !brk_f && last_vld && (last_key == {ext_f, rx_byte});

  // Remember the last accepted make; breaks and errors forget it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (rx_err || (push_req && brk_f)) begin
      last_vld <= 1'b0;
    end else if (wr_en && !brk_f) begin
      last_vld <= 1'b1;
      last_key <= {ext_f, rx_byte};
    end
  end
`else
  assign rep_drop = 1'b0;
`endif

  // Storage array; contents are only observable through the valid head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ext_f, brk_f, rx_byte};
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign evt.out_valid = (wr_ptr != rd_ptr);
  assign evt.out_code  = evt.out_valid ? head[7:0] : 8'h00;
  assign evt.out_break = evt.out_valid & head[8];
  assign evt.out_ext   = evt.out_valid & head[9];

  // ------------------------------------------------------ status counters
  // Sticky overflow, saturating error count, wrapping break count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      err_cnt   <= 8'h00;
      break_cnt <= 8'h00;
    end else begin
      if (ovf_set)                      overflow  <= 1'b1;
      if (rx_err && err_cnt != 8'hFF)   err_cnt   <= err_cnt + 8'd1;
      if (push_req && brk_f)            break_cnt <= break_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: drives PS/2 frames on the pins and
// compares every popped event and the status counters against a byte-level
// model of the keyboard protocol kept in queues and integers.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int SS    = 3;
  localparam int TO    = 300;
  localparam int HALF  = 10;   // clk cycles per PS/2 clock half-period
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic       clk, resetn, ps2_clk, ps2_data;
  logic       overflow;
  logic [7:0] err_cnt, break_cnt;

  ps2_rx_fifo_if intf();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt       (intf),
    .overflow  (overflow),
    .err_cnt   (err_cnt),
    .break_cnt (break_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;

  // ---------------- reference model (protocol level)
  logic [9:0] exp_q[$];       // {ext, brk, code}
  bit         m_ext, m_brk, m_ovf, m_last_vld, blocked;
  logic [8:0] m_last_key;
  int         m_err, m_bcnt;

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_last_vld = 0; m_last_key = '0;
    m_err = 0; m_bcnt = 0;
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
    m_ext = 0; m_brk = 0; m_last_vld = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    bit drop;
    if (bad) model_err();
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      drop = FILT_EN && !m_brk && m_last_vld && (m_last_key == {m_ext, b});
      if (m_brk) begin
        m_bcnt = (m_bcnt + 1) % 256;
        m_last_vld = 0;
      end
      if (!drop) begin
        if (blocked && exp_q.size() == DEPTH) m_ovf = 1;
        else begin
          exp_q.push_back({m_ext, m_brk, b});
          if (!m_brk) begin m_last_vld = 1; m_last_key = {m_ext, b}; end
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ---------------- consumer monitor: each pop must match the model head
  always @(negedge clk) begin
    logic [9:0] e;
    if (resetn && intf.out_valid && intf.out_ready) begin
      checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got ext=%0b brk=%0b code=%h, model queue empty",
                 intf.out_ext, intf.out_break, intf.out_code);
      end else begin
        e = exp_q.pop_front();
        if ({intf.out_ext, intf.out_break, intf.out_code} !== e) begin
          errors++;
          $display("FAIL pop_event got %h want %h",
                   {intf.out_ext, intf.out_break, intf.out_code}, e);
        end
      end
    end
  end

  // ---------------- pin drivers
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    model_byte(b, bad);
    send_bits(fr, 11);
    repeat (HALF) @(posedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 intf.out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", intf.out_valid); end
    checks++; if (intf.out_code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", intf.out_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++; if (break_cnt !== 8'h00) begin errors++; $display("FAIL reset_break_cnt got %0d want 0", break_cnt); end
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    set_ready(1'b1);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    send_byte(8'hF0, 0); send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL basic_err_cnt got %0d want %0d", err_cnt, m_err); end
    checks++; if (break_cnt !== 8'(m_bcnt)) begin errors++; $display("FAIL basic_break_cnt got %0d want %0d", break_cnt, m_bcnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d events outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_parity();
    send_byte(8'h1C, 1);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL parity_err_cnt got %0d want %0d", err_cnt, m_err); end
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL parity_valid got %b want 0", intf.out_valid); end
    send_byte(8'h1C, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL parity_recover got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    set_ready(1'b0);
    blocked = 1;
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 0);
    @(negedge clk);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, m_ovf); end
    checks++; if (intf.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", intf.out_valid); end
    checks++; if (intf.out_code !== exp_q[0][7:0]) begin errors++; $display("FAIL ovf_head got %h want %h", intf.out_code, exp_q[0][7:0]); end
    blocked = 0;
    set_ready(1'b1);
    n = 0;
    while (intf.out_valid && n < 50) begin @(posedge clk); n++; end
    @(negedge clk);
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout got valid=%b want 0", intf.out_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_count got %0d outstanding want 0", exp_q.size()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_ready(1'b1);
    send_byte(8'hE0, 0);
    send_bits(11'b000_1110_0000, 5);
    model_err();
    repeat (TO + 60) @(posedge clk);
    @(negedge clk);
    checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL timeout_err_cnt got %0d want %0d", err_cnt, m_err); end
    send_byte(8'h1C, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_recover got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hF0, 0);
    send_bits(11'b000_1110_0000, 3);
    do_reset();
    send_byte(8'h1C, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (break_cnt !== 8'(m_bcnt)) begin errors++; $display("FAIL midreset_break_cnt got %0d want %0d", break_cnt, m_bcnt); end
    checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL midreset_err_cnt got %0d want %0d", err_cnt, m_err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_event got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_typematic();
    int p0;
    do_reset();
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'h1C, 0);
    repeat (4) @(posedge clk); @(negedge clk);
    checks++;
    if (pop_cnt - p0 != (FILT_EN ? 1 : 3)) begin
      errors++; $display("FAIL typematic_count got %0d want %0d", pop_cnt - p0, FILT_EN ? 1 : 3);
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r == 1) b = 8'hE0;
      else if (r == 2 || r == 3) b = 8'hF0;
      send_byte(b, r == 0);
    end
    repeat (4) @(posedge clk); @(negedge clk);
    checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, m_err); end
    checks++; if (break_cnt !== 8'(m_bcnt)) begin errors++; $display("FAIL rand_break_cnt got %0d want %0d", break_cnt, m_bcnt); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow got %b want %b", overflow, m_ovf); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_events got %0d outstanding want 0", exp_q.size()); end
  endtask

  initial begin
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    intf.out_ready = 1'b0;
    blocked = 0;
    resetn = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_typematic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with a scan-code decoder and an output FIFO. It deserialises 11-bit PS/2 frames and folds the `E0` (extended) and `F0` (break) prefixes into flags on each key event. It buffers the events in a FIFO with a valid/ready output port and counts frame errors and break events. It sits between the board's PS/2 pins and the keyboard consumer (UART/console or MMIO register block).

## Interface
- `FIFO_DEPTH`, default 8: number of event entries; power of two, ≥2.
- `SYNC_STAGES`, default 3: synchroniser flops on `ps2_clk`/`ps2_data`; ≥2.
- `TIMEOUT_CYC`, default 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned.
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_code`  out  8  head scan code (prefixes stripped).
- `out_ext`  out  1  head event was `E0`-prefixed.
- `out_break`  out  1  head event was `F0`-prefixed (key release).
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `err_cnt`  out  8  count of rejected frames and timeouts; saturates at 255.
- `break_cnt`  out  8  count of break events pushed into the FIFO; wraps at 256.

## Operation
- Both pins pass through `SYNC_STAGES` flops. The sample strobe is the registered falling edge of the synchronised `ps2_clk` (previous sample 1, current sample 0).
- Bit counter 0..10. On each strobe:
  - Counts 0..9: the synchronised `ps2_data` is stored in `buf[count]` and the counter increments.
  - Count 10: the frame is checked, then the counter returns to 0.
- A frame is valid when all three hold: `buf[0]`==0 (start bit), `ps2_data`==1 (stop bit), and XOR of `buf[9:1]`==1 (odd parity).
- Invalid frame:
  - byte discarded;
  - `err_cnt` increments (saturating);
  - decoder flags cleared.
- Timeout: while count≠0, a counter counts cycles with no strobe. When it reaches `TIMEOUT_CYC`:
  - bit counter goes to 0;
  - `err_cnt` increments;
  - decoder flags cleared.
- Decoder holds two flags, `ext_f` and `brk_f`, cleared at reset. Each valid byte is handled as follows:
  - `E0`: sets `ext_f`.
  - `F0`: sets `brk_f`. Prefix order does not matter; `E0 F0 xx` and `F0 E0 xx` both give ext=1, break=1.
  - Any other byte: pushes `{ext_f, brk_f, byte}`, clears both flags, and increments `break_cnt` if `brk_f` was set.
- FIFO is first-word-fall-through: `out_code`/`out_ext`/`out_break` show the head entry whenever `out_valid`=1. A pop happens in a cycle with `out_valid && out_ready`.
- FIFO boundary behaviour:
  - Push while full with no pop in the same cycle: the entry is dropped and `overflow` is set. It stays set until reset.
  - Push and pop in the same cycle while full: both are accepted and `overflow` is not set.
  - Pop while empty: ignored.
- `out_ready` may be held high permanently. `out_valid` and the head fields stay stable until the head is popped.

## Timing
- All outputs are 0 at reset, and the FIFO is emptied. Reset mid-frame discards the partial frame and any pending flags.
- Strobe timing: the strobe occurs `SYNC_STAGES`+1 cycles after a `ps2_clk` pin fall.
- Frame check and FIFO write happen on the same edge as the 11th strobe. `out_valid` rises 1 cycle later if the FIFO was empty.
- `break_cnt` and `err_cnt` update on the same edge as the check or timeout.
- Pop latency: the next entry (or `out_valid`=0) appears on the cycle after the pop.
- Minimum spacing between strobes is assumed to be ≥ 4 `clk` cycles; PS/2 is 10–16.7 kHz.

## Configuration
- `PS2_RX_TYPEMATIC_FILTER_EN` defined: a make event (break=0) whose `{ext, code}` equals the last pushed make is dropped, provided no break has been pushed since. Such a drop does not set `overflow` and does not count as an error. Any break event, error or reset clears the remembered make.
- Not defined: every decoded event is pushed, including typematic repeats.

## Test plan
- Frame `1C` (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), `out_ready`=1 → one entry: code=1C, ext=0, break=0; `err_cnt`=0.
- `F0`(parity 1) then `1C` → one entry: code=1C, break=1; `break_cnt`=1.
- `E0 F0 75` → one entry: code=75, ext=1, break=1.
- `1C` sent with parity bit flipped to 1 → no entry; `err_cnt`=1. A following valid `1C` decodes normally.
- `out_ready`=0 with `FIFO_DEPTH`+1 distinct makes sent → `FIFO_DEPTH` entries held and `overflow`=1. Draining returns them in order and `out_valid` falls after the last.
- 5 strobes then idle `TIMEOUT_CYC` cycles → `err_cnt`=1, then a full `1C` frame decodes correctly. With `PS2_RX_TYPEMATIC_FILTER_EN` defined, `1C 1C 1C` yields exactly one entry.
